// File: rtl/approx_mul_row_sequencer.sv
// Multi-cycle controller for the 8x8 approximate half-adder-array multiplier:
// registers operands, captures the four row vectors, then accumulates them serially.
module approx_mul_row_sequencer #(
  parameter logic [3:0] ROW_MASK    = 4'b1111,
  parameter bit         ZERO_BYPASS = 1'b1,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_x,
  input  logic [7:0]       in_y,
  output logic [7:0]       mul_x,
  output logic [7:0]       mul_y,
  input  logic [6:0]       row0_b,
  input  logic [6:0]       row1_b,
  input  logic [6:0]       row2_b,
  input  logic [6:0]       row3_b,
  input  logic [8:0]       row0_t,
  input  logic [8:0]       row1_t,
  input  logic [8:0]       row2_t,
  input  logic [8:0]       row3_t,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      product,
  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both 1; valid never drops and its payload never changes until that edge.

  typedef enum logic [1:0] {IDLE, CAPT, ACC, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  idx;
  logic [15:0] acc;
  logic [15:0] term;
  logic [9:0]  rv [4];
  logic [9:0]  rv_in [4];
  logic        zero_op;

  // Row value: sum vector plus carry vector weighted by 4.
  assign rv_in[0] = 10'(row0_t) + {1'b0, row0_b, 2'b00};
  assign rv_in[1] = 10'(row1_t) + {1'b0, row1_b, 2'b00};
  assign rv_in[2] = 10'(row2_t) + {1'b0, row2_b, 2'b00};
  assign rv_in[3] = 10'(row3_t) + {1'b0, row3_b, 2'b00};

  assign zero_op   = (in_x == 8'd0) || (in_y == 8'd0);
  assign term      = ROW_MASK[idx] ? (16'(rv[idx]) << {idx, 1'b0}) : 16'd0;
  assign product   = acc;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (ZERO_BYPASS && zero_op) ? DONE : CAPT;
      end
      CAPT: state_nxt = ACC;
      ACC:  if (idx == 2'd3) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mul_x    <= 8'd0;
      mul_y    <= 8'd0;
      acc      <= 16'd0;
      idx      <= 2'd0;
      op_count <= '0;
      for (int k = 0; k < 4; k++) rv[k] <= 10'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          mul_x <= in_x;
          mul_y <= in_y;
          acc   <= 16'd0;
        end
        CAPT: begin
          for (int k = 0; k < 4; k++) rv[k] <= rv_in[k];
          acc <= 16'd0;
          idx <= 2'd0;
        end
        ACC: begin
          acc <= acc + term;
          idx <= idx + 2'd1;
        end
        DONE: if (out_ready && (op_count != {CNT_W{1'b1}})) op_count <= op_count + 1'b1;
        default: ;
      endcase
    end
  end

endmodule
